// File: rtl/stage1_ctrl_pkg.sv
// Shared definitions for the stage1 control FSM: state and opcode
// encodings, regfile write-source codes and an opcode legality helper.
package stage1_ctrl_pkg;

    localparam int unsigned ST_W = 4;

    // Binary state encoding; any value above S_HALT is treated as S_IDLE.
    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_DECODE = 4'd3,
        S_RDA    = 4'd4,
        S_RDB    = 4'd5,
        S_ALU    = 4'd6,
        S_MEMRD  = 4'd7,
        S_MWAIT  = 4'd8,
        S_MEMWR  = 4'd9,
        S_WB     = 4'd10,
        S_HALT   = 4'd11
    } state_e;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MOVI = 3'b001;
    localparam logic [2:0] OP_ALU  = 3'b010;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;
    localparam logic [1:0] VSEL_MEM = 2'b10;

    // 101 and 110 are the only unassigned opcodes.
    function automatic logic op_legal(input logic [2:0] op);
        return !((op == 3'b101) || (op == 3'b110));
    endfunction

endpackage

// File: rtl/stage1_ctrl.sv
// Multi-cycle control FSM for the stage1 fetch/execute datapath.
// Moore outputs decoded from the state register, latched opcode and
// sticky error flag; one instruction in flight at a time.
module stage1_ctrl
    import stage1_ctrl_pkg::*;
#(
    parameter int data_width = 16,
    parameter int st_width   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [data_width-1:0] ir,
    output logic                  loadpc,
    output logic                  loadir,
    output logic                  msel,
    output logic                  mwrite,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic [1:0]            vsel,
    output logic                  write,
    output logic                  halted,
    output logic                  err
);

    logic [st_width-1:0] state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                err_q, err_d;
    state_e              cur;
    state_e              nxt;
    state_e              fetch_or_idle;
    logic [2:0]          ir_op;
    logic                unused_ir;

    assign ir_op     = ir[data_width-1 -: 3];
    assign unused_ir = ^ir[data_width-4:0];

    // Map the raw state register onto the enum; out-of-range codes fall to idle.
    always_comb begin
        cur = S_IDLE;
        if (state_q <= st_width'(S_HALT)) begin
            cur = state_e'(state_q[ST_W-1:0]);
        end
    end

    // Next-state, opcode latch and sticky error computation.
    always_comb begin
        fetch_or_idle = run ? S_FETCH : S_IDLE;
        nxt           = S_IDLE;
        op_d          = op_q;
        err_d         = err_q;
        case (cur)
            S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
            S_FETCH:  nxt = S_FWAIT;
            S_FWAIT:  nxt = S_DECODE;
            S_DECODE: begin
                op_d = ir_op;
                if (!op_legal(ir_op)) begin
                    err_d = 1'b1;
                    nxt   = S_HALT;
                end else begin
                    case (ir_op)
                        OP_NOP:                 nxt = fetch_or_idle;
                        OP_MOVI:                nxt = S_WB;
                        OP_ALU, OP_LDR, OP_STR: nxt = S_RDA;
                        default:                nxt = S_HALT;
                    endcase
                end
            end
            S_RDA:    nxt = S_RDB;
            S_RDB:    nxt = S_ALU;
            S_ALU: begin
                case (op_q)
                    OP_ALU:  nxt = S_WB;
                    OP_LDR:  nxt = S_MEMRD;
                    OP_STR:  nxt = S_MEMWR;
                    default: nxt = S_IDLE;
                endcase
            end
            S_MEMRD:  nxt = S_MWAIT;
            S_MWAIT:  nxt = S_WB;
            S_MEMWR:  nxt = fetch_or_idle;
            S_WB:     nxt = fetch_or_idle;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IDLE;
        endcase
        state_d = st_width'(nxt);
    end

    // State, opcode and error registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Moore strobe decode; every strobe defaults low.
    always_comb begin
        loadpc = 1'b0;
        loadir = 1'b0;
        msel   = 1'b0;
        mwrite = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        vsel   = VSEL_C;
        write  = 1'b0;
        halted = 1'b0;
        case (cur)
            S_FWAIT:  loadir = 1'b1;
            S_DECODE: loadpc = 1'b1;
            S_RDA:    loada  = 1'b1;
            S_RDB:    loadb  = 1'b1;
            S_ALU:    loadc  = 1'b1;
            S_MEMRD,
            S_MWAIT:  msel   = 1'b1;
            S_MEMWR: begin
                msel   = 1'b1;
                mwrite = 1'b1;
            end
            S_WB: begin
                write = 1'b1;
                case (op_q)
                    OP_MOVI: vsel = VSEL_IMM;
                    OP_LDR:  vsel = VSEL_MEM;
                    default: vsel = VSEL_C;
                endcase
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

    assign err = err_q;

endmodule
